// File: rtl/bcd_scan_display.sv
// ---------------------------------------------------------------------------
// bcd_scan_display
//
// Display stage for the calculator datapath. An 8-bit unsigned result is
// converted to three BCD digits by a sequential double-dabble engine (one
// shift per clock) and shown on a 4-digit common-anode 7-segment display by
// time-multiplexing the digit selects.
//
// Parameters
//   SCAN_DIV : clk cycles each digit stays selected (>= 2).
//
// Ports
//   clk    in   system clock, all state on the rising edge
//   rst_n  in   asynchronous, active-low reset
//   value  in   [7:0] unsigned binary value to display
//   load   in   one-cycle strobe requesting conversion of value
//   busy   out  high while a conversion is running; load is ignored then
//   seg    out  [6:0] active-low segments {g,f,e,d,c,b,a}
//   an     out  [3:0] active-low one-hot digit select, an[0] = ones
//   dp     out  decimal point, active-low, always off
// ---------------------------------------------------------------------------
module bcd_scan_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam int         PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Active-low 0-9 table; anything else (never produced by the converter)
  // falls back to blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Converter state
  // -------------------------------------------------------------------------
  logic [1:0]  state_reg, state_next;
  logic [7:0]  bin_reg,   bin_next;
  logic [11:0] bcd_reg,   bcd_next;
  logic [2:0]  cnt_reg,   cnt_next;
  logic [3:0]  ones_reg,  ones_next;
  logic [3:0]  tens_reg,  tens_next;
  logic [3:0]  hund_reg,  hund_next;

  // Add-3 correction applied to every nibble before each shift.
  logic [11:0] bcd_adj;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                  ? bcd_reg[4*gi +: 4] + 4'd3
                                  : bcd_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    bcd_next   = bcd_reg;
    cnt_next   = cnt_reg;
    ones_next  = ones_reg;
    tens_next  = tens_reg;
    hund_next  = hund_reg;

    case (state_reg)
      IDLE: begin
        if (load) begin
          bin_next   = value;
          bcd_next   = 12'd0;
          cnt_next   = 3'd0;
          state_next = CONV;
        end
      end

      CONV: begin
        // Shift {bcd, bin} left by one after the add-3 correction.
        bcd_next = {bcd_adj[10:0], bin_reg[7]};
        bin_next = {bin_reg[6:0], 1'b0};
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) begin
          state_next = COMMIT;
        end
      end

      COMMIT: begin
        hund_next  = bcd_reg[11:8];
        tens_next  = bcd_reg[7:4];
        ones_next  = bcd_reg[3:0];
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      bin_reg   <= 8'd0;
      bcd_reg   <= 12'd0;
      cnt_reg   <= 3'd0;
      ones_reg  <= 4'd0;
      tens_reg  <= 4'd0;
      hund_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      bcd_reg   <= bcd_next;
      cnt_reg   <= cnt_next;
      ones_reg  <= ones_next;
      tens_reg  <= tens_next;
      hund_reg  <= hund_next;
    end
  end

  // busy covers both CONV and COMMIT, so a load on the commit edge is
  // dropped and the first accepted reload is the edge after commit.
  assign busy = (state_reg != IDLE);

  // -------------------------------------------------------------------------
  // Scanner
  // -------------------------------------------------------------------------
  logic [PW-1:0] pre_reg, pre_next;
  logic [1:0]    idx_reg, idx_next;
  logic [6:0]    seg_reg, seg_next;
  logic [3:0]    an_reg,  an_next;

  logic          advance;
  logic [1:0]    slot_idx;
  logic [3:0]    slot_nib;
  logic          slot_blank;
  logic [6:0]    slot_seg;
  logic [3:0]    slot_an;

  assign advance  = (pre_reg == PRE_LAST);
  assign slot_idx = idx_reg + 2'd1;

  // Digit source and leading-zero blanking for the slot about to start.
  // Sampling the display registers here (not after commit) means a commit
  // landing on an advance edge shows up from the following slot.
  always_comb begin
    slot_nib   = 4'd0;
    slot_blank = 1'b1;
    case (slot_idx)
      2'd0: begin
        slot_nib   = ones_reg;
        slot_blank = 1'b0;
      end
      2'd1: begin
        slot_nib   = tens_reg;
        slot_blank = (hund_reg == 4'd0) && (tens_reg == 4'd0);
      end
      2'd2: begin
        slot_nib   = hund_reg;
        slot_blank = (hund_reg == 4'd0);
      end
      default: begin
        slot_nib   = 4'd0;
        slot_blank = 1'b1;
      end
    endcase
  end

  assign slot_seg = slot_blank ? SEG_BLANK : seg7(slot_nib);

  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign slot_an[gi] = (slot_idx != 2'(gi));
    end
  endgenerate

  always_comb begin
    pre_next = pre_reg + PW'(1);
    idx_next = idx_reg;
    seg_next = seg_reg;
    an_next  = an_reg;
    if (advance) begin
      pre_next = '0;
      idx_next = slot_idx;
      seg_next = slot_seg;
      an_next  = slot_an;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_reg <= '0;
      idx_reg <= 2'd0;
      seg_reg <= SEG_ZERO;
      an_reg  <= 4'b1110;
    end else begin
      pre_reg <= pre_next;
      idx_reg <= idx_next;
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_bcd_scan_display.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_display
//
// Self-checking bench for bcd_scan_display with SCAN_DIV = 4. A behavioural
// model (decimal arithmetic on the displayed number, edge counting for the
// scan position) predicts seg/an/busy/dp after every clock; a table of known
// values checks the per-slot segment patterns, and hand-written sequences
// cover dropped loads, back-to-back reloads and mid-conversion reset.
// ---------------------------------------------------------------------------
module tb_bcd_scan_display;

  localparam int SD = 4;
  localparam logic [6:0] BLK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = 8'd0;
  logic       load = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  always #5 clk = ~clk;

  bcd_scan_display #(.SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .load  (load),
    .busy  (busy),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int         m_t;        // edges since reset release
  int         m_idx;      // scan position
  logic [6:0] m_seg;
  int         m_disp;     // number currently in the display registers
  int         m_pend;
  bit         m_busy;
  int         m_commit_t;

  function automatic logic [6:0] digit_seg(int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b1000000;  1: s = 7'b1111001;  2: s = 7'b0100100;
      3: s = 7'b0110000;  4: s = 7'b0011001;  5: s = 7'b0010010;
      6: s = 7'b0000010;  7: s = 7'b1111000;  8: s = 7'b0000000;
      9: s = 7'b0010000;  default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] slot_seg(int idx, int v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (idx)
      0:       return digit_seg(o);
      1:       return (h == 0 && t == 0) ? 7'b1111111 : digit_seg(t);
      2:       return (h == 0) ? 7'b1111111 : digit_seg(h);
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_t    = 0;
    m_idx  = 0;
    m_disp = 0;
    m_busy = 0;
    m_seg  = slot_seg(0, 0);
  endtask

  task automatic model_edge();
    bit busy_before;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_t++;
    busy_before = m_busy;
    if (m_t % SD == 0) begin
      m_idx = (m_idx + 1) % 4;
      m_seg = slot_seg(m_idx, m_disp);   // pre-commit digits
    end
    if (m_busy && m_t == m_commit_t) begin
      m_disp = m_pend;
      m_busy = 0;
    end
    if (!busy_before && load) begin
      m_busy     = 1;
      m_pend     = int'(value);
      m_commit_t = m_t + 9;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_an;
    exp_an = ~(4'b0001 << m_idx);
    chk("seg",  32'(seg),  32'(m_seg));
    chk("an",   32'(an),   32'(exp_an));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("dp",   32'(dp),   32'd1);
  endtask

  // One clock: inputs already set at the previous falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_load(logic [7:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // ---------------- table of known values ----------------
  typedef struct {
    logic [7:0] v;
    logic [6:0] s_ones;
    logic [6:0] s_tens;
    logic [6:0] s_hund;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int bc;
    logic [3:0] seen;

    vecs[0] = '{8'd9,   7'b0010000, BLK,        BLK};
    vecs[1] = '{8'd255, 7'b0010010, 7'b0010010, 7'b0100100};
    vecs[2] = '{8'd105, 7'b0010010, 7'b1000000, 7'b1111001};
    vecs[3] = '{8'd40,  7'b1000000, 7'b0011001, BLK};
    vecs[4] = '{8'd0,   7'b1000000, BLK,        BLK};
    vecs[5] = '{8'd100, 7'b1000000, 7'b1000000, 7'b1111001};
    vecs[6] = '{8'd17,  7'b1111000, 7'b1111001, BLK};

    model_reset();

    // Reset held for 3 cycles, then released.
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_an",   32'(an),   32'(4'b1110));
    chk("rst_seg",  32'(seg),  32'(7'b1000000));
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (5 * SD) step();

    // Table-driven conversions.
    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].v);
      bc = 0;
      while (busy && bc < 20) begin
        bc++;
        step();
      end
      chk("busy_len", 32'(bc), 32'd9);
      repeat (4 * SD + 1) step();
      seen = 4'b0000;
      for (int k = 0; k < 4 * SD; k++) begin
        step();
        case (an)
          4'b1110: begin chk("tbl_ones", 32'(seg), 32'(vecs[i].s_ones)); seen[0] = 1'b1; end
          4'b1101: begin chk("tbl_tens", 32'(seg), 32'(vecs[i].s_tens)); seen[1] = 1'b1; end
          4'b1011: begin chk("tbl_hund", 32'(seg), 32'(vecs[i].s_hund)); seen[2] = 1'b1; end
          4'b0111: begin chk("tbl_blank", 32'(seg), 32'(BLK));           seen[3] = 1'b1; end
          default: ;
        endcase
      end
      chk("tbl_slots", 32'(seen), 32'(4'b1111));
      $display("vector value=%0d checked", vecs[i].v);
    end

    // Load during busy is dropped; load on the first idle edge is accepted.
    do_load(8'd37);
    repeat (3) step();
    do_load(8'd200);
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      step();
    end
    chk("drop_busy_len", 32'(bc), 32'd5);
    do_load(8'd81);
    chk("reload_accept", 32'(busy), 32'd1);
    repeat (12 + 4 * SD) step();
    $display("drop/reload sequence value=37,200,81 checked");

    // Reset during a conversion of 255, then convert 6.
    do_load(8'd255);
    repeat (4) step();
    @(posedge clk);
    model_edge();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_an",   32'(an),   32'(4'b1110));
    chk("async_seg",  32'(seg),  32'(7'b1000000));
    chk("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    do_load(8'd6);
    repeat (10 + 8 * SD) step();
    $display("mid-conversion reset then value=6 checked");

    // Random loads, including held strobes and loads while busy.
    for (int r = 0; r < 40; r++) begin
      value = 8'($urandom_range(0, 255));
      load  = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      load  = 1'b0;
      repeat ($urandom_range(0, 14)) step();
      $display("random transaction %0d value=%0d", r, value);
    end
    repeat (10 + 4 * SD) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
